// File: rtl/game_round_sequencer_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : game_round_sequencer_pkg
// Brief   : Shared types, constants and helpers for the LED memory game.
// Revision: 1.0 - initial release
// ============================================================================
package game_round_sequencer_pkg;

  // Controller states, 3-bit binary encoding
  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_GEN      = 3'd1,
    ST_SHOW_ON  = 3'd2,
    ST_SHOW_OFF = 3'd3,
    ST_WAIT_IN  = 3'd4,
    ST_PAUSE    = 3'd5,
    ST_WIN      = 3'd6,
    ST_LOSE     = 3'd7
  } state_e;

  localparam logic [15:0] LFSR_SEED  = 16'hACE1;
  localparam logic [15:0] LFSR_MASK  = 16'hB400;
  localparam logic [3:0]  LED_ALL_ON = 4'b1111;
  localparam logic [3:0]  LED_LOSE   = 4'b1001;

  // Symbol 0..3 to the LED / button it names
  function automatic logic [3:0] onehot4(input logic [1:0] v);
    onehot4 = 4'b0001 << v;
  endfunction

  // Inverse of onehot4; only meaningful for a single set bit
  function automatic logic [1:0] onehot4_to_sym(input logic [3:0] v);
    case (v)
      4'b0010: onehot4_to_sym = 2'd1;
      4'b0100: onehot4_to_sym = 2'd2;
      4'b1000: onehot4_to_sym = 2'd3;
      default: onehot4_to_sym = 2'd0;
    endcase
  endfunction

  // One step of the right-shifting Galois LFSR
  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    lfsr_next = s[0] ? ({1'b0, s[15:1]} ^ LFSR_MASK) : {1'b0, s[15:1]};
  endfunction

endpackage : game_round_sequencer_pkg
`default_nettype wire

// File: rtl/game_round_sequencer_button_edge_sync.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : button_edge_sync
// Brief   : Two-flop synchroniser per button bit followed by a rising-edge
//           detector. btn_rise is high for one cycle per synced 0->1 step.
// Revision: 1.0 - initial release
// ============================================================================
module button_edge_sync (
  input  logic       osc_clk,
  input  logic       reset_n,
  input  logic [3:0] btn_raw,
  output logic [3:0] btn_sync,
  output logic [3:0] btn_rise
);

  logic [3:0] meta_q, meta_d;
  logic [3:0] sync_q, sync_d;
  logic [3:0] prev_q, prev_d;

  // Shift chain: raw -> meta -> sync -> prev (prev is sync delayed by one)
  always_comb begin
    meta_d = btn_raw;
    sync_d = meta_q;
    prev_d = sync_q;
  end

  // Synchroniser and history flops
  always_ff @(posedge osc_clk or negedge reset_n) begin
    if (!reset_n) begin
      meta_q <= '0;
      sync_q <= '0;
      prev_q <= '0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign btn_sync = sync_q;
  assign btn_rise = sync_q & ~prev_q;

endmodule : button_edge_sync
`default_nettype wire

// File: rtl/game_round_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : game_round_sequencer
// Brief   : Memory-game controller. Draws a pattern from an LFSR, plays a
//           growing prefix of it on the LEDs, checks the player's presses and
//           finishes in WIN or LOSE.
// Revision: 1.0 - initial release
// ============================================================================
module game_round_sequencer
  import game_round_sequencer_pkg::*;
#(
  parameter int unsigned STEP_CYCLES    = 50_000_000,
  parameter int unsigned GAP_CYCLES     = 12_500_000,
  parameter int unsigned TIMEOUT_CYCLES = 250_000_000,
  parameter int unsigned PAT_LEN        = 4
) (
  input  logic       osc_clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic [3:0] button,
  output logic [3:0] led,
  output logic       busy,
  output logic       win,
  output logic       lose,
  output logic [3:0] level
);

  // One counter serves every interval, so size it for the longest one
  localparam int unsigned MAX_SG  = (STEP_CYCLES > GAP_CYCLES) ? STEP_CYCLES : GAP_CYCLES;
  localparam int unsigned MAX_CYC = (MAX_SG > TIMEOUT_CYCLES) ? MAX_SG : TIMEOUT_CYCLES;
  localparam int unsigned TW      = $clog2(MAX_CYC) + 1;

  localparam logic [TW-1:0] STEP_LAST    = TW'(STEP_CYCLES - 1);
  localparam logic [TW-1:0] GAP_LAST     = TW'(GAP_CYCLES - 1);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]    LAST_LEVEL   = 4'(PAT_LEN);

  // Button front end
  logic [3:0] btn_sync;
  logic [3:0] btn_rise;

  button_edge_sync u_btn_sync (
    .osc_clk  (osc_clk),
    .reset_n  (reset_n),
    .btn_raw  (button),
    .btn_sync (btn_sync),
    .btn_rise (btn_rise)
  );

  // Registered state
  state_e        state_q, state_d;
  logic [15:0]   lfsr_q, lfsr_d;
  logic [1:0]    pat_q [8];
  logic [1:0]    pat_d [8];
  logic [2:0]    idx_q, idx_d;
  logic [3:0]    level_q, level_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [3:0]    led_q, led_d;
  logic          busy_q, busy_d;
  logic          win_q, win_d;
  logic          lose_q, lose_d;

  // LFSR bit pairs, one candidate symbol per pattern slot
  logic [1:0] lfsr_pairs [8];

  for (genvar g = 0; g < 8; g++) begin : g_lfsr_pairs
    assign lfsr_pairs[g] = lfsr_q[2*g+1 : 2*g];
  end

  // Press classification: exactly one new edge and nothing else held
  logic       press_any;
  logic       press_single;
  logic       press_valid;
  logic [1:0] press_sym;
  logic       press_match;
  logic       step_is_last;
  logic       win_flip;

  always_comb begin
    press_any    = |btn_rise;
    press_single = press_any && ((btn_rise & (btn_rise - 4'd1)) == 4'd0);
    press_valid  = press_single && ((btn_sync & ~btn_rise) == 4'd0);
    press_sym    = onehot4_to_sym(btn_rise);
    press_match  = press_valid && (press_sym == pat_q[idx_q]);
    step_is_last = ({1'b0, idx_q} == (level_q - 4'd1));
  end

  // Next-state, datapath and registered-output computation
  always_comb begin
    state_d  = state_q;
    lfsr_d   = lfsr_next(lfsr_q);
    pat_d    = pat_q;
    idx_d    = idx_q;
    level_d  = level_q;
    timer_d  = timer_q + TW'(1);
    win_flip = 1'b0;

    case (state_q)
      ST_IDLE: begin
        timer_d = '0;
        if (start) state_d = ST_GEN;
      end
      ST_GEN: begin
        pat_d   = lfsr_pairs;
        level_d = 4'd1;
        idx_d   = 3'd0;
        state_d = ST_SHOW_ON;
      end
      ST_SHOW_ON: begin
        if (timer_q == STEP_LAST) state_d = ST_SHOW_OFF;
      end
      ST_SHOW_OFF: begin
        if (timer_q == GAP_LAST) begin
          if (step_is_last) begin
            idx_d   = 3'd0;
            state_d = ST_WAIT_IN;
          end else begin
            idx_d   = idx_q + 3'd1;
            state_d = ST_SHOW_ON;
          end
        end
      end
      ST_WAIT_IN: begin
        // A press takes priority over a timeout in the same cycle
        if (press_any) begin
          timer_d = '0;
          if (!press_match) begin
            state_d = ST_LOSE;
          end else if (!step_is_last) begin
            idx_d = idx_q + 3'd1;
          end else if (level_q == LAST_LEVEL) begin
            state_d = ST_WIN;
          end else begin
            level_d = level_q + 4'd1;
            idx_d   = 3'd0;
            state_d = ST_PAUSE;
          end
        end else if (timer_q == TIMEOUT_LAST) begin
          state_d = ST_LOSE;
        end
      end
      ST_PAUSE: begin
        if (timer_q == GAP_LAST) begin
          idx_d   = 3'd0;
          state_d = ST_SHOW_ON;
        end
      end
      ST_WIN: begin
        if (start) begin
          state_d = ST_GEN;
        end else if (timer_q == STEP_LAST) begin
          timer_d  = '0;
          win_flip = 1'b1;
        end
      end
      ST_LOSE: begin
        timer_d = '0;
        if (start) state_d = ST_GEN;
      end
      default: state_d = ST_IDLE;
    endcase

    // The shared timer restarts on every state change
    if (state_d != state_q) timer_d = '0;

    // Outputs are registered against the state being entered
    case (state_d)
      ST_SHOW_ON: led_d = onehot4(pat_d[idx_d]);
      ST_WAIT_IN: led_d = btn_sync;
      ST_WIN:     led_d = (state_q != ST_WIN) ? LED_ALL_ON : (win_flip ? ~led_q : led_q);
      ST_LOSE:    led_d = LED_LOSE;
      default:    led_d = 4'd0;
    endcase
    busy_d = !((state_d == ST_IDLE) || (state_d == ST_WIN) || (state_d == ST_LOSE));
    win_d  = (state_d == ST_WIN);
    lose_d = (state_d == ST_LOSE);
  end

  // All controller state and outputs
  always_ff @(posedge osc_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      lfsr_q  <= LFSR_SEED;
      pat_q   <= '{default: 2'b00};
      idx_q   <= '0;
      level_q <= '0;
      timer_q <= '0;
      led_q   <= '0;
      busy_q  <= 1'b0;
      win_q   <= 1'b0;
      lose_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      pat_q   <= pat_d;
      idx_q   <= idx_d;
      level_q <= level_d;
      timer_q <= timer_d;
      led_q   <= led_d;
      busy_q  <= busy_d;
      win_q   <= win_d;
      lose_q  <= lose_d;
    end
  end

  assign led   = led_q;
  assign busy  = busy_q;
  assign win   = win_q;
  assign lose  = lose_q;
  assign level = level_q;

endmodule : game_round_sequencer
`default_nettype wire

// File: tb/tb_game_round_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : tb_game_round_sequencer
// Brief   : Self-checking bench for game_round_sequencer with short intervals.
// Revision: 1.0 - initial release
// ============================================================================
module tb_game_round_sequencer;

  localparam int STEP = 4;
  localparam int GAP  = 2;
  localparam int TMO  = 20;
  localparam int PLEN = 4;

  logic       osc_clk = 1'b0;
  logic       reset_n;
  logic       start;
  logic [3:0] button;
  logic [3:0] led;
  logic       busy;
  logic       win;
  logic       lose;
  logic [3:0] level;

  game_round_sequencer #(
    .STEP_CYCLES    (STEP),
    .GAP_CYCLES     (GAP),
    .TIMEOUT_CYCLES (TMO),
    .PAT_LEN        (PLEN)
  ) dut (
    .osc_clk (osc_clk),
    .reset_n (reset_n),
    .start   (start),
    .button  (button),
    .led     (led),
    .busy    (busy),
    .win     (win),
    .lose    (lose),
    .level   (level)
  );

  always #5 osc_clk = ~osc_clk;

  // Expected output of one clock cycle
  typedef struct {
    string      name;
    logic [3:0] led;
    logic       busy;
    logic       win;
    logic       lose;
    logic [3:0] level;
  } exp_t;

  // First-press scenarios of round 1
  typedef struct {
    string      name;
    int         kind;      // 0 correct, 1 wrong single, 2 buttons 0+1, 3 all four
    logic [3:0] exp_led;
    logic       exp_lose;
    logic [3:0] exp_level;
  } vec_t;

  exp_t        exp_q[$];
  vec_t        vecs[4];
  int          checks = 0;
  int          errors = 0;
  logic [15:0] lfsr_m;
  logic [1:0]  pat [PLEN];
  logic [3:0]  cur_level;

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    logic [15:0] r;
    r = {1'b0, s[15:1]};
    if (s[0]) r = r ^ 16'hB400;
    return r;
  endfunction

  function automatic logic [3:0] oh(input logic [1:0] v);
    return 4'b0001 << v;
  endfunction

  // Reference LFSR: reset to the seed, one step per clock
  always @(posedge osc_clk or negedge reset_n) begin
    if (!reset_n) lfsr_m <= 16'hACE1;
    else          lfsr_m <= lfsr_step(lfsr_m);
  end

  task automatic push(input string n, input logic [3:0] l, input logic b,
                      input logic w, input logic lo, input logic [3:0] lv);
    exp_t e;
    e.name = n; e.led = l; e.busy = b; e.win = w; e.lose = lo; e.level = lv;
    exp_q.push_back(e);
  endtask

  // Compare the oldest expectation at the falling edge, return 1 after rising edge
  task automatic tick();
    exp_t e;
    @(negedge osc_clk);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      checks++;
      if (led !== e.led || busy !== e.busy || win !== e.win || lose !== e.lose || level !== e.level) begin
        errors++;
        $display("FAIL %s @%0t: got led=%b busy=%b win=%b lose=%b level=%0d, expected led=%b busy=%b win=%b lose=%b level=%0d",
                 e.name, $time, led, busy, win, lose, level, e.led, e.busy, e.win, e.lose, e.level);
      end
    end
    @(posedge osc_clk);
    #1;
  endtask

  task automatic check_now(input string n, input logic [3:0] got, input logic [3:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s @%0t: got %b, expected %b", n, $time, got, want);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      tick();
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d expectations left, expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic push_show(input logic [3:0] lv);
    for (int i = 0; i < int'(lv); i++) begin
      repeat (STEP) push("show_on", oh(pat[i]), 1'b1, 1'b0, 1'b0, lv);
      repeat (GAP)  push("show_off", 4'd0, 1'b1, 1'b0, 1'b0, lv);
    end
    push("wait_in_entry", 4'd0, 1'b1, 1'b0, 1'b0, lv);
  endtask

  // Start a game, capture its pattern and check round-1 playback
  task automatic start_game(input logic [3:0] prev_level);
    logic [15:0] s;
    start = 1'b1;
    tick();
    start = 1'b0;
    s = lfsr_m;
    for (int k = 0; k < PLEN; k++) pat[k] = s[2*k +: 2];
    push("gen", 4'd0, 1'b1, 1'b0, 1'b0, prev_level);
    push_show(4'd1);
    drain();
  endtask

  // Button pattern held two cycles; returns once the decision is visible
  task automatic press(input logic [3:0] b);
    button = b;
    tick();
    tick();
    button = 4'd0;
    tick();
  endtask

  task automatic play_round(input logic [3:0] lv);
    for (int i = 0; i < int'(lv); i++) begin
      press(oh(pat[i]));
      if (i < int'(lv) - 1) begin
        push("wait_in_mirror", oh(pat[i]), 1'b1, 1'b0, 1'b0, lv);
        tick();
      end else if (int'(lv) == PLEN) begin
        for (int r = 0; r < 3; r++)
          repeat (STEP) push("win_blink", (r == 1) ? 4'b0000 : 4'b1111, 1'b0, 1'b1, 1'b0, 4'(PLEN));
      end else begin
        repeat (GAP) push("pause", 4'd0, 1'b1, 1'b0, 1'b0, lv + 4'd1);
        push_show(lv + 4'd1);
      end
    end
    drain();
  endtask

  initial begin
    logic [15:0] nxt;
    int          n;
    logic [3:0]  b;

    vecs[0] = '{name: "v_correct",  kind: 0, exp_led: 4'b0000, exp_lose: 1'b0, exp_level: 4'd2};
    vecs[1] = '{name: "v_double01", kind: 2, exp_led: 4'b1001, exp_lose: 1'b1, exp_level: 4'd1};
    vecs[2] = '{name: "v_wrong",    kind: 1, exp_led: 4'b1001, exp_lose: 1'b1, exp_level: 4'd1};
    vecs[3] = '{name: "v_all_four", kind: 3, exp_led: 4'b1001, exp_lose: 1'b1, exp_level: 4'd1};

    reset_n = 1'b0;
    start   = 1'b0;
    button  = 4'd0;
    repeat (3) tick();
    check_now("reset_led", led, 4'd0);
    check_now("reset_level", level, 4'd0);
    check_now("reset_flags", {1'b0, busy, win, lose}, 4'd0);
    reset_n = 1'b1;

    // Idle with no start for 100 cycles
    repeat (100) push("idle", 4'd0, 1'b0, 1'b0, 1'b0, 4'd0);
    drain();

    // Wait for the LFSR state that yields pattern {0,1,2,3}
    n   = 0;
    nxt = lfsr_step(lfsr_m);
    while (nxt[7:0] != 8'hE4 && n < 20000) begin
      tick();
      nxt = lfsr_step(lfsr_m);
      n++;
    end
    start_game(4'd0);

    // Full win
    for (int r = 1; r <= PLEN; r++) play_round(4'(r));
    cur_level = 4'(PLEN);

    // First-press scenarios; the correct one then fails in round 2
    for (int v = 0; v < 4; v++) begin
      start_game(cur_level);
      case (vecs[v].kind)
        0:       b = oh(pat[0]);
        1:       b = oh(pat[0] ^ 2'd3);
        2:       b = 4'b0011;
        default: b = 4'b1111;
      endcase
      press(b);
      push(vecs[v].name, vecs[v].exp_led, !vecs[v].exp_lose, 1'b0, vecs[v].exp_lose, vecs[v].exp_level);
      if (vecs[v].kind == 0) begin
        repeat (GAP - 1) push("pause", 4'd0, 1'b1, 1'b0, 1'b0, 4'd2);
        push_show(4'd2);
        drain();
        press(oh(pat[0] ^ 2'd3));
        repeat (3) push("round2_wrong_lose", 4'b1001, 1'b0, 1'b0, 1'b1, 4'd2);
        drain();
        cur_level = 4'd2;
      end else begin
        repeat (2) push("wrong_lose_hold", 4'b1001, 1'b0, 1'b0, 1'b1, 4'd1);
        drain();
        cur_level = 4'd1;
      end
    end

    // Timeout with no press
    start_game(cur_level);
    repeat (TMO - 1) push("wait_no_press", 4'd0, 1'b1, 1'b0, 1'b0, 4'd1);
    repeat (3) push("timeout_lose", 4'b1001, 1'b0, 1'b0, 1'b1, 4'd1);
    drain();

    // Press decided on the last cycle before timeout; start ignored while busy
    start_game(4'd1);
    repeat (TMO - 1) push("wait_late_press", 4'd0, 1'b1, 1'b0, 1'b0, 4'd1);
    repeat (GAP) push("late_press_pause", 4'd0, 1'b1, 1'b0, 1'b0, 4'd2);
    repeat (2) push("late_show_on", oh(pat[0]), 1'b1, 1'b0, 1'b0, 4'd2);
    start = 1'b1;
    repeat (3) tick();
    start = 1'b0;
    repeat (13) tick();
    press(oh(pat[0]));
    drain();

    // Asynchronous reset in the middle of SHOW_ON
    reset_n = 1'b0;
    #1;
    check_now("async_reset_led", led, 4'd0);
    check_now("async_reset_level", level, 4'd0);
    check_now("async_reset_flags", {1'b0, busy, win, lose}, 4'd0);
    tick();
    tick();
    reset_n = 1'b1;
    repeat (10) push("idle_after_reset", 4'd0, 1'b0, 1'b0, 1'b0, 4'd0);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_game_round_sequencer
`default_nettype wire
